// File: rtl/controller_emulator_m.sv
`default_nettype none
// ============================================================================
//  Module      : controller_emulator_m
//  Description : Device-side model of a 4021-style serial game pad. Tracks
//                the host latch/clock pair and shifts out button state.
//  Revision    : 1.0 - initial release
// ============================================================================
module controller_emulator_m #(
    parameter int NUM_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                controller_latch,
    input  logic                controller_clk,
    output logic                controller_data_B,
    input  logic [NUM_BITS-1:0] buttons_in,
    output logic                frame_done,
    output logic [7:0]          frame_count
);

    localparam int CNT_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic                   r_clk_s_d;
    logic [1:0]             r_state;
    logic [NUM_BITS-1:0]    r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_data_b;
    logic                   r_frame_done;
    logic [7:0]             r_frame_count;

    logic w_latch_s;
    logic w_clk_s;
    logic w_clk_rise;

    assign w_latch_s  = r_latch_sync[SYNC_STAGES-1];
    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_clk_rise = w_clk_s & ~r_clk_s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_sync  <= '0;
            r_clk_sync    <= '0;
            r_clk_s_d     <= 1'b0;
            r_state       <= c_st_idle;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_data_b      <= 1'b1;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], controller_latch};
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], controller_clk};
            r_clk_s_d    <= w_clk_s;
            r_frame_done <= 1'b0;

            // Latch overrides everything, including a coincident clock rise.
            if (w_latch_s) begin
                r_state   <= c_st_load;
                r_shreg   <= buttons_in;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    c_st_load:  r_state <= c_st_shift;
                    c_st_shift: begin
                        if (w_clk_rise) begin
                            if (r_bit_cnt < c_last_bit) begin
                                r_shreg   <= {r_shreg[NUM_BITS-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + c_one;
                                // Frame counts as complete once the last bit is on the wire.
                                if (r_bit_cnt == c_last_bit - c_one) begin
                                    r_frame_done  <= 1'b1;
                                    r_frame_count <= r_frame_count + 8'd1;
                                end
                            end else begin
                                r_state <= c_st_done;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            r_data_b <= (r_state == c_st_done) ? 1'b0 : ~r_shreg[NUM_BITS-1];
        end
    end

    assign controller_data_B = r_data_b;
    assign frame_done        = r_frame_done;
    assign frame_count       = r_frame_count;

endmodule
`default_nettype wire
